fpu_addsub_arbiter: RTL and testbench

//  Shares one combinational fpuAddSub16 datapath among NUM_REQ requesters.
//  - Round-robin arbitration; each requester uses a valid/ready request channel.
//  - Operands and result are registered; a single tagged response channel returns the result.
//  - Sits between FPU-client units (decode/issue) and the shared add/sub core.

---
 rtl/fpu_lib_pkg.sv | 37 +++
 rtl/fpuAddSub16.sv | 110 +++++++++++
 rtl/fpu_rr_arbiter.sv | 30 +++
 rtl/fpu_addsub_arbiter.sv | 121 ++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_lib_pkg.sv
// rtl/fpu_lib_pkg.sv - shared fp16 types, flag structs and arbiter state encoding
package fpu_lib;

  typedef logic [15:0] fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } opStatusFlag_t;

  typedef enum logic {
    FPU_ADD = 1'b0,
    FPU_SUB = 1'b1
  } fpuOp_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } fpuArbState_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

  function automatic fpuOp_t sub_to_op(input logic sub);
    return sub ? FPU_SUB : FPU_ADD;
  endfunction

endpackage

// File: rtl/fpuAddSub16.sv
// rtl/fpuAddSub16.sv - combinational binary16 add/subtract, round-to-nearest-even
module fpuAddSub16
  import fpu_lib::*;
(
  input  fp16_t         in1,
  input  fp16_t         in2,
  input  fpuOp_t        op,
  output fp16_t         out,
  output condCode_t     cond,
  output opStatusFlag_t status
);

  logic        sa, sb, big_s, sml_s, sr, swap;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [14:0] mag_a, mag_b;
  logic [5:0]  big_e, sml_e, e, d;
  logic [10:0] big_m, sml_m;
  logic [13:0] tmp, sh, lost_mask;
  logic        sticky, g, rs, up, inexact;
  logic [14:0] mx, my, mr;
  logic [11:0] rnd;

  always_comb begin
    sa     = in1[15];
    sb     = in2[15] ^ (op == FPU_SUB);
    a_nan  = (in1[14:10] == 5'h1f) && (in1[9:0] != 10'h0);
    b_nan  = (in2[14:10] == 5'h1f) && (in2[9:0] != 10'h0);
    a_inf  = (in1[14:10] == 5'h1f) && (in1[9:0] == 10'h0);
    b_inf  = (in2[14:10] == 5'h1f) && (in2[9:0] == 10'h0);

    // order by magnitude so the subtraction below never goes negative
    swap   = in2[14:0] > in1[14:0];
    mag_a  = swap ? in2[14:0] : in1[14:0];
    mag_b  = swap ? in1[14:0] : in2[14:0];
    big_s  = swap ? sb : sa;
    sml_s  = swap ? sa : sb;
    big_e  = (mag_a[14:10] == 5'h0) ? 6'd1 : {1'b0, mag_a[14:10]};
    sml_e  = (mag_b[14:10] == 5'h0) ? 6'd1 : {1'b0, mag_b[14:10]};
    big_m  = {mag_a[14:10] != 5'h0, mag_a[9:0]};
    sml_m  = {mag_b[14:10] != 5'h0, mag_b[9:0]};

    d         = big_e - sml_e;
    tmp       = {sml_m, 3'b000};
    sh        = '0;
    sticky    = 1'b0;
    lost_mask = '0;
    if (d >= 6'd14) begin
      sticky = |tmp;
    end else begin
      sh        = tmp >> d;
      lost_mask = (14'h1 << d) - 14'h1;
      sticky    = |(tmp & lost_mask);
    end

    mx = {1'b0, big_m, 3'b000};
    my = {1'b0, sh[13:1], sh[0] | sticky};
    mr = (big_s == sml_s) ? mx + my : mx - my;
    e  = big_e;
    sr = big_s;

    if (mr[14]) begin
      mr = {1'b0, mr[14:2], mr[1] | mr[0]};
      e  = e + 6'd1;
    end else begin
      // left-normalise, stopping at the subnormal exponent
      for (int i = 0; i < 13; i++) begin
        if (!mr[13] && e > 6'd1) begin
          mr = mr << 1;
          e  = e - 6'd1;
        end
      end
    end
    if (mr == 15'h0 && big_s != sml_s) sr = 1'b0;

    g       = mr[2];
    rs      = |mr[1:0];
    inexact = |mr[2:0];
    up      = g & (rs | mr[3]);
    rnd     = {1'b0, mr[13:3]} + {11'h0, up};
    if (rnd[11]) begin
      rnd = {1'b0, rnd[11:1]};
      e   = e + 6'd1;
    end

    status = '0;
    out    = '0;
    if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) begin
      out            = FP16_QNAN;
      status.invalid = 1'b1;
    end else if (a_inf) begin
      out = {sa, 5'h1f, 10'h0};
    end else if (b_inf) begin
      out = {sb, 5'h1f, 10'h0};
    end else if (e >= 6'd31) begin
      out             = {sr, 5'h1f, 10'h0};
      status.overflow = 1'b1;
      status.inexact  = 1'b1;
    end else begin
      out              = {sr, rnd[10] ? e[4:0] : 5'h0, rnd[9:0]};
      status.inexact   = inexact;
      status.underflow = inexact & ~rnd[10];
    end

    cond.z = (out[14:0] == 15'h0);
    cond.n = out[15];
    cond.c = status.inexact;
    cond.v = status.overflow;
  end

endmodule

// File: rtl/fpu_rr_arbiter.sv
// rtl/fpu_rr_arbiter.sv - combinational round-robin picker: first req at or after ptr
module fpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin sharing of one fpuAddSub16 among NUM_REQ clients
// Optional per-requester grant and stall counters under FPU_ARB_STATS_EN.
module fpu_addsub_arbiter
  import fpu_lib::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_sub,
  input  fp16_t              req_in1 [NUM_REQ],
  input  fp16_t              req_in2 [NUM_REQ],
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output fp16_t              resp_out,
  output condCode_t          resp_cond,
  output opStatusFlag_t      resp_status,
  output logic               busy
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt [NUM_REQ],
  output logic [15:0]        stall_cnt
`endif
);

  fpuArbState_t        state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                accept;
  logic                op_sub;
  fp16_t               op_in1, op_in2;
  logic [ID_W-1:0]     op_id;
  fp16_t               fpu_out;
  condCode_t           fpu_cond;
  opStatusFlag_t       fpu_status;

  fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  fpuAddSub16 u_fpu (
    .in1    (op_in1),
    .in2    (op_in2),
    .op     (sub_to_op(op_sub)),
    .out    (fpu_out),
    .cond   (fpu_cond),
    .status (fpu_status)
  );

  assign req_ready  = (state == ARB_IDLE) ? gnt : '0;
  assign accept     = (state == ARB_IDLE) && (|req_valid);
  assign resp_valid = (state == ARB_RESP);
  assign busy       = (state != ARB_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (accept) state_nxt = ARB_EXEC;
      ARB_EXEC: state_nxt = ARB_RESP;
      ARB_RESP: if (resp_ready) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // response regs only load in EXEC, so they hold steady through a RESP stall
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr      <= '0;
      op_sub      <= 1'b0;
      op_in1      <= '0;
      op_in2      <= '0;
      op_id       <= '0;
      resp_id     <= '0;
      resp_out    <= '0;
      resp_cond   <= '0;
      resp_status <= '0;
    end else begin
      if (accept) begin
        op_sub <= req_sub[gnt_id];
        op_in1 <= req_in1[gnt_id];
        op_in2 <= req_in2[gnt_id];
        op_id  <= gnt_id;
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (state == ARB_EXEC) begin
        resp_id     <= op_id;
        resp_out    <= fpu_out;
        resp_cond   <= fpu_cond;
        resp_status <= fpu_status;
      end
    end
  end

`ifdef FPU_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && grant_cnt[gnt_id] != 16'hffff)
        grant_cnt[gnt_id] <= grant_cnt[gnt_id] + 16'd1;
      if (state == ARB_RESP && !resp_ready && stall_cnt != 16'hffff)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - directed vector bench for fpu_addsub_arbiter
module tb_fpu_addsub_arbiter;
  import fpu_lib::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_valid, req_ready, req_sub;
  fp16_t         req_in1 [N];
  fp16_t         req_in2 [N];
  logic          resp_valid, resp_ready, busy;
  logic [IDW-1:0] resp_id;
  fp16_t         resp_out;
  condCode_t     resp_cond;
  opStatusFlag_t resp_status;
`ifdef FPU_ARB_STATS_EN
  logic [15:0]   grant_cnt [N];
  logic [15:0]   stall_cnt;
`endif

  fpu_addsub_arbiter #(.NUM_REQ(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sub     (req_sub),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_out    (resp_out),
    .resp_cond   (resp_cond),
    .resp_status (resp_status),
    .busy        (busy)
`ifdef FPU_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  cond;
    logic [3:0]  stat;
  } vec_t;

  vec_t vt [8];

  // present one request at a negedge, wait for its grant, return at the EXEC negedge
  task automatic issue(input int id, input logic sub, input logic [15:0] a, input logic [15:0] b);
    int n;
    n           = 0;
    req_sub[id] = sub;
    req_in1[id] = a;
    req_in2[id] = b;
    req_valid   = '0;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 8) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("grant", 16'(req_ready), 16'(1 << id));
    @(posedge clock);
    @(negedge clock);
    req_valid = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    int   last_c;

    vt[0] = '{0, 1'b0, 16'h3C00, 16'h4000, 16'h4200, 4'b0000, 4'b0000};
    vt[1] = '{1, 1'b1, 16'h4000, 16'h4000, 16'h0000, 4'b1000, 4'b0000};
    vt[2] = '{2, 1'b1, 16'h4400, 16'h3C00, 16'h4200, 4'b0000, 4'b0000};
    vt[3] = '{3, 1'b0, 16'hBC00, 16'h3800, 16'hB800, 4'b0010, 4'b0000};
    vt[4] = '{0, 1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 4'b0101};
    vt[5] = '{1, 1'b1, 16'h7C00, 16'h7C00, 16'h7E00, 4'b0000, 4'b1000};
    vt[6] = '{2, 1'b0, 16'h3C00, 16'h1000, 16'h3C00, 4'b0100, 4'b0001};
    vt[7] = '{3, 1'b0, 16'h3C01, 16'h1000, 16'h3C02, 4'b0100, 4'b0001};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_sub    = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_in1[i] = '0;
      req_in2[i] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 16'(req_ready), 16'h0);
    chk("rst_resp_valid", 16'(resp_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_resp_out", resp_out, 16'h0);
    chk("rst_resp_id", 16'(resp_id), 16'h0);
    reset_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      issue(vt[k].id, vt[k].sub, vt[k].a, vt[k].b);
      chk("exec_resp_valid", 16'(resp_valid), 16'h0);
      chk("exec_busy", 16'(busy), 16'h1);
      @(negedge clock);
      chk("resp_valid", 16'(resp_valid), 16'h1);
      chk("resp_id", 16'(resp_id), 16'(vt[k].id));
      chk("resp_out", resp_out, vt[k].out);
      chk("resp_cond", 16'(resp_cond), 16'(vt[k].cond));
      chk("resp_status", 16'(resp_status), 16'(vt[k].stat));
      @(negedge clock);
      chk("idle_after_resp", 16'(busy), 16'h0);
    end

    // all four requesting: expect 0,1,2,3,0 three cycles apart
    for (int i = 0; i < N; i++) begin
      req_in1[i] = 16'h3C00;
      req_in2[i] = 16'h3C00;
    end
    req_sub   = '0;
    req_valid = 4'hF;
    last_c    = 0;
    for (int gi = 0; gi < 5; gi++) begin
      int n;
      n = 0;
      #1;
      while (req_ready == '0 && n < 8) begin
        @(negedge clock);
        #1;
        n++;
      end
      chk("rr_grant", 16'(req_ready), 16'(1 << (gi % N)));
      if (gi > 0) chk("rr_spacing", 16'(cyc - last_c), 16'd3);
      last_c = cyc;
      @(negedge clock);
    end
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);

    // stalled response with rr_ptr now at 1
    resp_ready = 1'b0;
    issue(1, 1'b0, 16'h3C00, 16'h4000);
    req_valid = 4'hF;
    @(negedge clock);
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("stall_resp_valid", 16'(resp_valid), 16'h1);
      chk("stall_resp_out", resp_out, 16'h4200);
      chk("stall_resp_id", 16'(resp_id), 16'h1);
      chk("stall_req_ready", 16'(req_ready), 16'h0);
      chk("stall_busy", 16'(busy), 16'h1);
      if (s < 4) begin
        @(negedge clock);
        #1;
      end
    end
    resp_ready = 1'b1;
    @(negedge clock);
    chk("stall_exit_valid", 16'(resp_valid), 16'h0);
    chk("stall_exit_busy", 16'(busy), 16'h0);
    req_valid = '0;

    // reset while EXEC drops the op and clears rr_ptr
    issue(2, 1'b0, 16'h4000, 16'h4000);
    chk("pre_rst_busy", 16'(busy), 16'h1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_resp_valid", 16'(resp_valid), 16'h0);
    chk("mid_rst_resp_out", resp_out, 16'h0);
    reset_n   = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("rst_ptr_zero", 16'(req_ready), 16'h1);
    req_valid = '0;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clock);
      saw = saw | resp_valid;
    end
    chk("no_stale_resp", 16'(saw), 16'h0);

    // req2 pulses while another op is in flight and must never be served
    resp_ready = 1'b0;
    issue(0, 1'b0, 16'h3C00, 16'h3C00);
    req_valid = 4'b0100;
    #1;
    chk("inflight_req_ready", 16'(req_ready), 16'h0);
    @(negedge clock);
    chk("inflight_resp_id", 16'(resp_id), 16'h0);
    chk("inflight_resp_out", resp_out, 16'h4000);
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clock);
    chk("inflight_idle", 16'(busy), 16'h0);
    saw = 1'b0;
    repeat (5) begin
      @(negedge clock);
      saw = saw | resp_valid;
    end
    chk("no_req2_resp", 16'(saw), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
